// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: datapath width, fetch FSM encoding,
// default reset PC and the sequential PC step.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;

    // Fetch buffer entry is {pc, instr}
    localparam int ENTRY_W = 2 * XLEN;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer. Entry 0 is always the head; a pop shifts entry 1
// down. Push/pop in the same cycle keeps the count and the order. Flush
// empties the buffer; a pop in the flush cycle is still taken by the consumer
// because the head is presented combinationally during that cycle.
module fetch_fifo
    import riscv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_push_data,
    input  logic               i_pop,
    input  logic               i_flush,
    output logic [ENTRY_W-1:0] o_head_data,
    output logic [1:0]         o_count
);

    logic [ENTRY_W-1:0] r_mem0;
    logic [ENTRY_W-1:0] r_mem1;
    logic [1:0]         r_count;
    logic               w_pop;
    logic               w_push;

    // Qualify pop/push so an empty pop or a full push without pop is ignored
    always_comb begin
        w_pop  = i_pop && (r_count != 2'd0);
        w_push = i_push && ((r_count != 2'd2) || w_pop);
    end

    // Storage and occupancy update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_mem0 <= i_push_data;
                    else                 r_mem1 <= i_push_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_mem0 <= i_push_data;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Head reads as zero while empty so stale entries never leak out
    always_comb begin
        o_head_data = (r_count != 2'd0) ? r_mem0 : '0;
        o_count     = r_count;
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: walks the PC through a combinational
// instruction memory and buffers {pc, instr} pairs in a 2-entry FIFO.
// Consumer handshake: a head transfers on any cycle where instr_valid and
// instr_ready are both high; instr_valid never depends on instr_ready.
// Redirect overrides everything: flush, load the new PC, keep running.
module imem_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            halt,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            busy,
    output fetch_state_t    o_dbg_state
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    w_pc_next;
    logic [XLEN-1:0]    w_redirect_target;
    logic               w_push;
    logic               w_pop;
    logic [1:0]         w_count;
    logic [ENTRY_W-1:0] w_head;

    fetch_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({r_pc, imem_rdata}),
        .i_pop       (w_pop),
        .i_flush     (redirect),
        .o_head_data (w_head),
        .o_count     (w_count)
    );

    // Next state, push decision and next PC; redirect wins over all else
    always_comb begin
        w_state_next      = r_state;
        w_push            = 1'b0;
        w_pop             = (w_count != 2'd0) && instr_ready;
        w_redirect_target = redirect_pc & ~32'h0000_0003;
        w_pc_next         = r_pc;
        if (redirect) begin
            w_pc_next = w_redirect_target;
            if (r_state != ST_IDLE) begin
                w_state_next = halt ? ST_DRAIN : ST_RUN;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) w_state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (halt) begin
                        w_state_next = ST_DRAIN;
                    end else if ((w_count != 2'd2) || w_pop) begin
                        w_push    = 1'b1;
                        w_pc_next = r_pc + PC_INC;
                    end
                end
                ST_DRAIN: begin
                    if ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop)) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // State and PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    // Output mapping from the PC register and buffer head
    always_comb begin
        imem_addr   = r_pc;
        instr_valid = (w_count != 2'd0);
        instr_pc    = w_head[ENTRY_W-1:XLEN];
        instr       = w_head[XLEN-1:0];
        busy        = (r_state != ST_IDLE);
        o_dbg_state = r_state;
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl. Inputs change just after the
// falling edge, outputs are sampled 1ns later, well away from the rising edge.
module tb_imem_fetch_ctrl;
    import riscv_pkg::*;

    logic         clk;
    logic         rst;
    logic         start;
    logic         halt;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic [31:0]  imem_addr;
    logic [31:0]  imem_rdata;
    logic         instr_valid;
    logic         instr_ready;
    logic [31:0]  instr;
    logic [31:0]  instr_pc;
    logic         busy;
    fetch_state_t dbg_state;

    logic [63:0]  exp_q[$];
    logic [63:0]  exp_e;
    int           n_pass;
    int           n_total;

    imem_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    // Memory model: data is a tag plus the low address half
    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; halt = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; instr_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Reset, start, let two entries fill with ready low; ends at count 2
    task automatic fill_full();
        do_reset();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; halt = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; instr_ready = 1'b0;
        #2;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", instr_valid); else n_pass++;
        n_total++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h expected 0", instr); else n_pass++;
        n_total++; if (instr_pc !== 32'h0) $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h expected 0", imem_addr); else n_pass++;
        n_total++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 6; i++) exp_q.push_back({32'(i * 4), 16'hC0DE, 16'(i * 4)});
        @(negedge clk); start = 1'b1; instr_ready = 1'b1; #1;
        n_total++; if (busy !== 1'b0) $display("FAIL stream_idle_busy: got %b expected 0", busy); else n_pass++;
        @(negedge clk); start = 1'b0; #1;
        n_total++; if (busy !== 1'b1) $display("FAIL stream_busy: got %b expected 1", busy); else n_pass++;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL stream_first_empty: got %b expected 0", instr_valid); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            n_total++;
            if (instr_valid !== 1'b1 || exp_q.size() == 0)
                $display("FAIL stream_head%0d: valid=%b queue=%0d, expected valid=1", i, instr_valid, exp_q.size());
            else begin
                exp_e = exp_q.pop_front();
                if ({instr_pc, instr} !== exp_e) $display("FAIL stream_head%0d: got %h expected %h", i, {instr_pc, instr}, exp_e);
                else n_pass++;
            end
        end
        instr_ready = 1'b0;
        n_total++; if (exp_q.size() != 0) $display("FAIL stream_drained: got %0d left expected 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_stall();
        fill_full();
        for (int i = 0; i < 3; i++) exp_q.push_back({32'(i * 4), 16'hC0DE, 16'(i * 4)});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_total++; if (imem_addr !== 32'h8) $display("FAIL stall_addr%0d: got %h expected 00000008", i, imem_addr); else n_pass++;
            n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) $display("FAIL stall_head%0d: valid=%b pc=%h expected valid=1 pc=0", i, instr_valid, instr_pc); else n_pass++;
        end
        @(negedge clk); instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            n_total++;
            if (instr_valid !== 1'b1 || exp_q.size() == 0)
                $display("FAIL stall_pop%0d: valid=%b queue=%0d, expected valid=1", i, instr_valid, exp_q.size());
            else begin
                exp_e = exp_q.pop_front();
                if ({instr_pc, instr} !== exp_e) $display("FAIL stall_pop%0d: got %h expected %h", i, {instr_pc, instr}, exp_e);
                else n_pass++;
            end
        end
        instr_ready = 1'b0;
        n_total++; if (exp_q.size() != 0) $display("FAIL stall_drained: got %0d left expected 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_redirect_full();
        fill_full();
        exp_q.push_back({32'h0, 32'hC0DE_0000});
        exp_q.push_back({32'h100, 32'hC0DE_0100});
        @(negedge clk); redirect = 1'b1; redirect_pc = 32'h103; instr_ready = 1'b1; #1;
        n_total++;
        if (instr_valid !== 1'b1 || exp_q.size() == 0)
            $display("FAIL redir_pop: valid=%b expected 1", instr_valid);
        else begin
            exp_e = exp_q.pop_front();
            if ({instr_pc, instr} !== exp_e) $display("FAIL redir_pop: got %h expected %h", {instr_pc, instr}, exp_e);
            else n_pass++;
        end
        @(negedge clk); redirect = 1'b0; #1;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL redir_flushed: got %b expected 0", instr_valid); else n_pass++;
        n_total++; if ({instr_pc, instr} !== 64'h0) $display("FAIL redir_empty_head: got %h expected 0", {instr_pc, instr}); else n_pass++;
        n_total++; if (imem_addr !== 32'h100) $display("FAIL redir_addr: got %h expected 00000100", imem_addr); else n_pass++;
        @(negedge clk); #1;
        n_total++;
        if (instr_valid !== 1'b1 || exp_q.size() == 0)
            $display("FAIL redir_new_head: valid=%b expected 1", instr_valid);
        else begin
            exp_e = exp_q.pop_front();
            if ({instr_pc, instr} !== exp_e) $display("FAIL redir_new_head: got %h expected %h", {instr_pc, instr}, exp_e);
            else n_pass++;
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_halt();
        fill_full();
        exp_q.push_back({32'h0, 32'hC0DE_0000});
        exp_q.push_back({32'h4, 32'hC0DE_0004});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); halt = (i == 0); instr_ready = 1'b1; #1;
            n_total++; if (busy !== 1'b1) $display("FAIL halt_busy%0d: got %b expected 1", i, busy); else n_pass++;
            n_total++;
            if (instr_valid !== 1'b1 || exp_q.size() == 0)
                $display("FAIL halt_pop%0d: valid=%b expected 1", i, instr_valid);
            else begin
                exp_e = exp_q.pop_front();
                if ({instr_pc, instr} !== exp_e) $display("FAIL halt_pop%0d: got %h expected %h", i, {instr_pc, instr}, exp_e);
                else n_pass++;
            end
        end
        n_total++; if (dbg_state !== ST_DRAIN) $display("FAIL halt_drain_state: got %0d expected %0d", dbg_state, ST_DRAIN); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_total++; if (busy !== 1'b0 || dbg_state !== ST_IDLE) $display("FAIL halt_idle%0d: busy=%b state=%0d expected busy=0 state=0", i, busy, dbg_state); else n_pass++;
            n_total++; if (instr_valid !== 1'b0 || imem_addr !== 32'h8) $display("FAIL halt_no_fetch%0d: valid=%b addr=%h expected valid=0 addr=00000008", i, instr_valid, imem_addr); else n_pass++;
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_idle_halt();
        int n;
        do_reset();
        n = $urandom_range(2, 5);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); halt = 1'b1; instr_ready = 1'($urandom_range(0, 1)); #1;
            n_total++; if (busy !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0) $display("FAIL idle_halt%0d: busy=%b valid=%b addr=%h expected 0/0/0", i, busy, instr_valid, imem_addr); else n_pass++;
        end
        @(negedge clk); halt = 1'b0; instr_ready = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        exp_q.push_back({32'hFFFF_FFFC, 32'hC0DE_FFFC});
        exp_q.push_back({32'h0, 32'hC0DE_0000});
        @(negedge clk); start = 1'b1; instr_ready = 1'b1;
        @(negedge clk); start = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL wrap_no_push: got %b expected 0", instr_valid); else n_pass++;
        @(negedge clk); redirect = 1'b0; #1;
        n_total++; if (imem_addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0) $display("FAIL wrap_addr: addr=%h valid=%b expected fffffffc/0", imem_addr, instr_valid); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_total++;
            if (instr_valid !== 1'b1 || exp_q.size() == 0)
                $display("FAIL wrap_head%0d: valid=%b expected 1", i, instr_valid);
            else begin
                exp_e = exp_q.pop_front();
                if ({instr_pc, instr} !== exp_e) $display("FAIL wrap_head%0d: got %h expected %h", i, {instr_pc, instr}, exp_e);
                else n_pass++;
            end
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        fill_full();
        #1;
        n_total++; if (instr_valid !== 1'b1) $display("FAIL areset_pre_valid: got %b expected 1", instr_valid); else n_pass++;
        #1; rst = 1'b1; #1;
        n_total++; if (instr_valid !== 1'b0) $display("FAIL areset_valid: got %b expected 0", instr_valid); else n_pass++;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL areset_addr: got %h expected 0", imem_addr); else n_pass++;
        n_total++; if (busy !== 1'b0 || {instr_pc, instr} !== 64'h0) $display("FAIL areset_outputs: busy=%b head=%h expected 0/0", busy, {instr_pc, instr}); else n_pass++;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_halt();
        test_idle_halt();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, begins fetching from IDLE.
REQ-005 SHALL have port halt, input, 1, stops new fetches and drains the buffer.
REQ-006 SHALL have port redirect, input, 1, flushes the buffer and loads a new PC (branch/jump).
REQ-007 SHALL have port redirect_pc, input, 32, target PC; bits [1:0] ignored and treated as 0.
REQ-008 SHALL have port imem_addr, output, 32, drives the instruction memory PC input; equals the internal PC register.
REQ-009 SHALL have port imem_rdata, input, 32, combinational instruction memory read data for imem_addr.
REQ-010 SHALL have port instr_valid, output, 1, buffer head holds a valid instruction.
REQ-011 SHALL have port instr_ready, input, 1, consumer accepts the head; transfer when instr_valid && instr_ready.
REQ-012 SHALL have port instr, output, 32, instruction at the buffer head.
REQ-013 SHALL have port instr_pc, output, 32, PC of the head instruction.
REQ-014 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN.
REQ-016 IDLE: no pushes; start -> RUN; halt ignored.
REQ-017 RUN: push {pc, imem_rdata} into a 2-entry FIFO and set pc <= pc+4 in every cycle where count<2, or count==2 with a pop in the same cycle.
REQ-018 RUN with halt (no redirect) -> DRAIN; no push occurs in that cycle.
REQ-019 DRAIN: no pushes; -> IDLE in the cycle the FIFO becomes empty, including when already empty on entry.
REQ-020 redirect SHALL have priority over push, halt and start: count <= 0, pc <= {redirect_pc[31:2],2'b00}; next state RUN from RUN/DRAIN, DRAIN if halt is also high, and IDLE remains IDLE.
REQ-021 A pop coinciding with redirect SHALL complete; all other entries are discarded.
REQ-022 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-023 instr_valid SHALL equal (count != 0); instr and instr_pc SHALL be 0 when count==0.
REQ-024 Fetch latency: an instruction fetched at cycle N SHALL appear at the head at cycle N+1 when the FIFO was empty.
REQ-025 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-026 Sustained throughput SHALL be one instruction per cycle with instr_ready held high.

Reset
REQ-027 On rst: state IDLE, pc RESET_PC, count 0, instr_valid 0, instr 0, instr_pc 0, busy 0, imem_addr RESET_PC; asserting rst mid-operation discards all buffered entries immediately.

Structure
REQ-028 The shared package riscv_pkg SHALL hold XLEN=32, the fetch state encoding, the default RESET_PC and the PC increment constant 4.
REQ-029 The 2-entry buffer SHALL be a sub-module fetch_fifo (64-bit entries {pc, instr}, push/pop/flush, count output).

Verification
(Memory model for all scenarios: imem_rdata = {16'hC0DE, imem_addr[15:0]}.)
REQ-030 rst, then start with instr_ready=1 -> heads 0xC0DE0000 (pc 0), 0xC0DE0004, 0xC0DE0008 on consecutive cycles; busy=1.
REQ-031 RUN with instr_ready=0 for 4 cycles -> count saturates at 2, imem_addr stops at 0x8, head remains pc 0x0 until ready returns.
REQ-032 Redirect to 0x103 while the FIFO is full, with pop in the same cycle -> popped entry accepted, others flushed, next head pc 0x100 with instr 0xC0DE0100.
REQ-033 halt with 2 entries, instr_ready=1 -> 2 pops, then IDLE and busy=0; no pc 0x8 entry delivered.
REQ-034 Redirect to 0xFFFF_FFFC in RUN -> heads pc 0xFFFF_FFFC then pc 0x0.
REQ-035 rst asserted mid-RUN with count=2 -> instr_valid=0 and imem_addr=RESET_PC immediately, without waiting for a clock edge.
